// File: rtl/amp_feature_extract_if.sv
// Envelope-sample and feature-result bundle for amp_feature_extract.
// The master drives the samples and the start pulse; the slave returns status and features.
interface amp_feature_extract_if #(
    parameter int unsigned IO_width = 14
);
    logic                       meas_start;
    logic                       env_valid;
    logic signed [IO_width-1:0] env_data;
    logic                       busy;
    logic                       meas_done;
    logic                       A_const;
    logic                       A_square;
    logic signed [IO_width-1:0] A_edge_interv;

    modport master (
        output meas_start, env_valid, env_data,
        input  busy, meas_done, A_const, A_square, A_edge_interv
    );

    modport slave (
        input  meas_start, env_valid, env_data,
        output busy, meas_done, A_const, A_square, A_edge_interv
    );
endinterface

// File: rtl/amp_feature_extract.sv
// Two-pass amplitude feature extractor: pass 1 finds the envelope min/max, pass 2 counts
// mid-band samples and the shortest interval between hysteresis level transitions.
module amp_feature_extract #(
    parameter int unsigned IO_width = 14,
    parameter int unsigned WIN_LEN  = 4096,
    parameter int unsigned CONST_TH = 64,
    parameter int unsigned MID_TH   = 128
) (
    input logic                 clk,
    input logic                 rst,
    amp_feature_extract_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIN_LEN + 1);
    localparam int unsigned XW   = IO_width + 1;
    localparam logic signed [IO_width-1:0] MaxI    = {1'b0, {(IO_width-1){1'b1}}};
    localparam logic        [IO_width-1:0] MaxIntv = {1'b0, {(IO_width-1){1'b1}}};

    typedef enum logic [1:0] {StIdle, StMinmax, StClassify, StDone} state_e;

    state_e                     state_q, state_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic signed [IO_width-1:0] min_q, min_d, max_q, max_d;
    logic signed [XW-1:0]       range_q, range_d, lo_q, lo_d, hi_q, hi_d, mid_q, mid_d;
    logic [CntW-1:0]            midcnt_q, midcnt_d;
    logic                       level_q, level_d, trans_q, trans_d, restart_q, restart_d;
    logic [1:0]                 ntrans_q, ntrans_d;
    logic [IO_width-1:0]        interv_q, interv_d, min_interv_q, min_interv_d;
    logic                       busy_q, busy_d, meas_done_q, meas_done_d;
    logic                       a_const_q, a_const_d, a_square_q, a_square_d;
    logic [IO_width-1:0]        a_edge_interv_q, a_edge_interv_d;

    logic signed [IO_width-1:0] min_nxt, max_nxt;
    logic signed [XW-1:0]       samp_x, min_x, max_x, range_nxt;

    assign samp_x    = {bus.env_data[IO_width-1], bus.env_data};
    assign min_nxt   = (bus.env_data < min_q) ? bus.env_data : min_q;
    assign max_nxt   = (bus.env_data > max_q) ? bus.env_data : max_q;
    assign min_x     = {min_nxt[IO_width-1], min_nxt};
    assign max_x     = {max_nxt[IO_width-1], max_nxt};
    // Extra bit keeps max - min exact even for full-scale swings.
    assign range_nxt = max_x - min_x;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        min_d           = min_q;
        max_d           = max_q;
        range_d         = range_q;
        lo_d            = lo_q;
        hi_d            = hi_q;
        mid_d           = mid_q;
        midcnt_d        = midcnt_q;
        level_d         = level_q;
        trans_d         = 1'b0;
        restart_d       = restart_q;
        ntrans_d        = ntrans_q;
        interv_d        = interv_q;
        min_interv_d    = min_interv_q;
        busy_d          = busy_q;
        meas_done_d     = 1'b0;
        a_const_d       = a_const_q;
        a_square_d      = a_square_q;
        a_edge_interv_d = a_edge_interv_q;

        // Transition flagged on the previous sample: fold its interval into the minimum.
        if (trans_q && (ntrans_q == 2'd2) && (interv_q < min_interv_q)) begin
            min_interv_d = interv_q;
        end

        unique case (state_q)
            StIdle: ;
            StMinmax: begin
                if (bus.env_valid) begin
                    min_d = min_nxt;
                    max_d = max_nxt;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntW'(WIN_LEN - 1)) begin
                        range_d      = range_nxt;
                        lo_d         = min_x + (range_nxt >>> 2);
                        hi_d         = max_x - (range_nxt >>> 2);
                        mid_d        = min_x + (range_nxt >>> 1);
                        cnt_d        = '0;
                        midcnt_d     = '0;
                        ntrans_d     = 2'd0;
                        interv_d     = '0;
                        restart_d    = 1'b0;
                        min_interv_d = MaxIntv;
                        state_d      = StClassify;
                    end
                end
            end
            StClassify: begin
                if (cnt_q == CntW'(WIN_LEN)) begin
                    // Drain cycle so the last transition reaches min_interv before DONE.
                    state_d = StDone;
                end else if (bus.env_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if ((samp_x > lo_q) && (samp_x < hi_q) && (midcnt_q != '1)) begin
                        midcnt_d = midcnt_q + 1'b1;
                    end
                    if (cnt_q == '0) begin
                        level_d = (samp_x >= mid_q);
                    end else begin
                        if (samp_x >= hi_q) begin
                            level_d = 1'b1;
                        end else if (samp_x <= lo_q) begin
                            level_d = 1'b0;
                        end
                        trans_d = (level_d != level_q);
                    end
                    if (restart_q) begin
                        interv_d = {{(IO_width-1){1'b0}}, 1'b1};
                    end else if (interv_q != MaxIntv) begin
                        interv_d = interv_q + 1'b1;
                    end
                    restart_d = trans_d;
                    if (trans_d && (ntrans_q != 2'd2)) begin
                        ntrans_d = ntrans_q + 2'd1;
                    end
                end
            end
            StDone: begin
                a_const_d       = (int'(range_q) < int'(CONST_TH));
                a_square_d      = !a_const_d && (int'(midcnt_q) <= int'(MID_TH));
                a_edge_interv_d = min_interv_q;
                meas_done_d     = 1'b1;
                busy_d          = 1'b0;
                state_d         = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A start wins over everything; a sample arriving with it is dropped.
        if (bus.meas_start) begin
            cnt_d   = '0;
            min_d   = MaxI;
            max_d   = -MaxI;
            trans_d = 1'b0;
            busy_d  = 1'b1;
            state_d = StMinmax;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            min_q           <= MaxI;
            max_q           <= -MaxI;
            range_q         <= '0;
            lo_q            <= '0;
            hi_q            <= '0;
            mid_q           <= '0;
            midcnt_q        <= '0;
            level_q         <= 1'b0;
            trans_q         <= 1'b0;
            restart_q       <= 1'b0;
            ntrans_q        <= 2'd0;
            interv_q        <= '0;
            min_interv_q    <= MaxIntv;
            busy_q          <= 1'b0;
            meas_done_q     <= 1'b0;
            a_const_q       <= 1'b0;
            a_square_q      <= 1'b0;
            a_edge_interv_q <= MaxIntv;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            min_q           <= min_d;
            max_q           <= max_d;
            range_q         <= range_d;
            lo_q            <= lo_d;
            hi_q            <= hi_d;
            mid_q           <= mid_d;
            midcnt_q        <= midcnt_d;
            level_q         <= level_d;
            trans_q         <= trans_d;
            restart_q       <= restart_d;
            ntrans_q        <= ntrans_d;
            interv_q        <= interv_d;
            min_interv_q    <= min_interv_d;
            busy_q          <= busy_d;
            meas_done_q     <= meas_done_d;
            a_const_q       <= a_const_d;
            a_square_q      <= a_square_d;
            a_edge_interv_q <= a_edge_interv_d;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.meas_done     = meas_done_q;
    assign bus.A_const       = a_const_q;
    assign bus.A_square      = a_square_q;
    assign bus.A_edge_interv = a_edge_interv_q;
endmodule

// File: tb/tb_amp_feature_extract.sv
// Randomized bench for amp_feature_extract: each window is scored against a batch
// reference computed from the whole sample record with plain arithmetic.
module tb_amp_feature_extract;
    localparam int unsigned IoW    = 14;
    localparam int unsigned WinLen = 16;
    localparam int unsigned ConstTh = 64;
    localparam int unsigned MidTh  = 2;
    localparam int MaxI = 8191;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    amp_feature_extract_if #(.IO_width(IoW)) bus ();

    amp_feature_extract #(
        .IO_width(IoW),
        .WIN_LEN (WinLen),
        .CONST_TH(ConstTh),
        .MID_TH  (MidTh)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int samp[2*WinLen];
    int sine_tab[16] = '{1000, 1383, 1707, 1924, 2000, 1924, 1707, 1383,
                         1000, 617, 293, 76, 0, 76, 293, 617};
    logic exp_const, exp_square;
    int   exp_interv;

    task automatic check_val(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_check(input string tag);
        check_val(tag, {bus.meas_done, bus.A_const, bus.A_square, bus.A_edge_interv},
                  {1'b0, exp_const, exp_square, 14'(exp_interv)});
    endtask

    task automatic gen(input int kind);
        int a, b, run, lvl;
        a = $urandom_range(0, 4000) - 2000;
        b = a + $urandom_range(0, 3000);
        run = 0;
        lvl = 0;
        for (int i = 0; i < 2 * WinLen; i++) begin
            case (kind)
                0: samp[i] = 1000;
                1: samp[i] = ((i / 4) % 2 == 1) ? 3000 : 200;
                2: samp[i] = sine_tab[(i + 8) % 16];
                3: samp[i] = ((i % 16) < 4 || (i % 16) == 8 || (i % 16) == 9) ? 200 : 3000;
                4: begin
                    if (run == 0) begin
                        lvl = 1 - lvl;
                        run = $urandom_range(1, 5);
                    end
                    run--;
                    samp[i] = (lvl == 1 ? b : a) + $urandom_range(0, 40);
                end
                default: samp[i] = $urandom_range(0, 16383) - 8192;
            endcase
        end
    endtask

    // Batch reference: pass 1 over samp[0..W-1], pass 2 over samp[W..2W-1].
    task automatic model();
        int mn, mx, rng, lo, hi, mid, midcnt, level, nl, last_t, mi, s;
        mn = samp[0];
        mx = samp[0];
        for (int i = 1; i < WinLen; i++) begin
            if (samp[i] < mn) mn = samp[i];
            if (samp[i] > mx) mx = samp[i];
        end
        rng = mx - mn;
        lo  = mn + rng / 4;
        hi  = mx - rng / 4;
        mid = mn + rng / 2;
        midcnt = 0;
        level  = (samp[WinLen] >= mid) ? 1 : 0;
        last_t = -1;
        mi     = MaxI;
        for (int j = 0; j < WinLen; j++) begin
            s = samp[WinLen + j];
            if (s > lo && s < hi) midcnt++;
            if (j > 0) begin
                nl = (s >= hi) ? 1 : (s <= lo) ? 0 : level;
                if (nl != level) begin
                    if (last_t >= 0 && (j - last_t) < mi) mi = j - last_t;
                    last_t = j;
                end
                level = nl;
            end
        end
        exp_const  = (rng < int'(ConstTh));
        exp_square = !exp_const && (midcnt <= int'(MidTh));
        exp_interv = mi;
    endtask

    task automatic start_meas(input string name);
        bus.meas_start = 1'b1;
        bus.env_valid  = 1'b1;
        bus.env_data   = 14'($urandom);
        tick();
        bus.meas_start = 1'b0;
        bus.env_valid  = 1'b0;
        check_val({name, ".busy_on"}, bus.busy, 1);
    endtask

    task automatic feed(input string name, input int n);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) begin
                bus.env_valid = 1'b0;
                bus.env_data  = 14'($urandom);
                tick();
                hold_check({name, ".hold"});
            end
            bus.env_valid = 1'b1;
            bus.env_data  = 14'(samp[k]);
            tick();
            hold_check({name, ".hold"});
        end
        bus.env_valid = 1'b0;
    endtask

    task automatic finish_run(input string name);
        int lat;
        lat = 0;
        while (bus.meas_done !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
        check_val({name, ".latency"}, lat, 2);
        model();
        check_val({name, ".const"}, bus.A_const, exp_const);
        check_val({name, ".square"}, bus.A_square, exp_square);
        check_val({name, ".interv"}, bus.A_edge_interv, exp_interv);
        check_val({name, ".busy_off"}, bus.busy, 0);
        tick();
        check_val({name, ".done_pulse"}, bus.meas_done, 0);
    endtask

    task automatic run_kind(input int kind, input string name);
        gen(kind);
        start_meas(name);
        feed(name, 2 * WinLen);
        finish_run(name);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.meas_start = 1'b0;
        bus.env_valid  = 1'b0;
        bus.env_data   = '0;
        repeat (3) tick();
        check_val("reset.busy", bus.busy, 0);
        check_val("reset.done", bus.meas_done, 0);
        check_val("reset.const", bus.A_const, 0);
        check_val("reset.square", bus.A_square, 0);
        check_val("reset.interv", bus.A_edge_interv, MaxI);
        rst = 1'b0;
        exp_const  = 1'b0;
        exp_square = 1'b0;
        exp_interv = MaxI;
        tick();

        run_kind(0, "const");
        check_val("plan.const", {bus.A_const, bus.A_square, bus.A_edge_interv}, {2'b10, 14'd8191});
        run_kind(1, "square");
        check_val("plan.square", {bus.A_const, bus.A_square, bus.A_edge_interv}, {2'b01, 14'd4});
        run_kind(2, "sine");
        check_val("plan.sine", {bus.A_const, bus.A_square, bus.A_edge_interv}, {2'b00, 14'd8});
        run_kind(3, "dip");
        check_val("plan.dip", bus.A_edge_interv, 2);

        for (int r = 0; r < 8; r++) begin
            run_kind(4 + (r % 2), $sformatf("rand%0d", r));
        end

        // Restart mid-CLASSIFY: first run must never complete.
        gen(1);
        start_meas("abort1");
        feed("abort1", WinLen + 5);
        gen(0);
        start_meas("abort2");
        feed("abort2", 2 * WinLen);
        finish_run("abort2");
        check_val("plan.abort", bus.A_const, 1);

        // Reset during MINMAX, then idle with and without valid samples.
        gen(5);
        start_meas("rstmm");
        feed("rstmm", 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("rstmm.busy", bus.busy, 0);
        check_val("rstmm.done", bus.meas_done, 0);
        check_val("rstmm.interv", bus.A_edge_interv, MaxI);
        exp_const  = 1'b0;
        exp_square = 1'b0;
        exp_interv = MaxI;
        repeat (3 * WinLen) begin
            tick();
            hold_check("rstmm.idle_hold");
            check_val("rstmm.idle_busy", bus.busy, 0);
        end
        gen(4);
        feed("rstmm.nostart", 2 * WinLen);
        repeat (4) begin
            tick();
            hold_check("rstmm.nostart_hold");
            check_val("rstmm.nostart_busy", bus.busy, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/amp_feature_extract.md
Name: amp_feature_extract

Overview:
- Measures the demodulated amplitude envelope over a fixed window of valid samples.
- Produces the three amplitude features used by the downstream signal-type decision stage: A_const, A_square and A_edge_interv.
- Runs in two passes. Pass 1 finds the envelope min/max. Pass 2 counts mid-band samples and the shortest interval between level transitions.
- Sits between the envelope/CORDIC magnitude path and the signal discriminator. meas_done drives that stage's judge trigger.

Parameters:
- IO_width, 14: envelope sample width (signed) and A_edge_interv width.
- WIN_LEN, 4096: valid samples per pass, >= 4.
- CONST_TH, 64: A_const is set when (max - min) < CONST_TH.
- MID_TH, 128: A_square is set when the mid-band sample count <= MID_TH.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- meas_start  in  1  single-cycle pulse; starts or restarts a measurement
- env_valid  in  1  env_data is valid this cycle
- env_data  in  IO_width  signed envelope sample
- busy  out  1  high from the cycle after meas_start until meas_done
- meas_done  out  1  single-cycle pulse; features updated this cycle
- A_const  out  1  envelope is constant
- A_square  out  1  envelope is two-level
- A_edge_interv  out  IO_width  minimum samples between transitions; signed, always >= 0

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: all outputs go to busy=0, meas_done=0, A_const=0, A_square=0, A_edge_interv = 2^(IO_width-1)-1 (MAXI). Reset has the same effect mid-measurement: the FSM returns to IDLE and no meas_done is issued.
- FSM states: IDLE, MINMAX, CLASSIFY, DONE.
  - IDLE: waits for meas_start.
  - meas_start in any state clears the sample counter, loads min=+max code and max=-max code, and moves to MINMAX next cycle. A start during MINMAX or CLASSIFY aborts the run with no meas_done.
- MINMAX:
  - On each env_valid, update min/max and increment the counter.
  - After the WIN_LEN-th valid sample, go to CLASSIFY.
  - Compute range = max - min in IO_width+1 bits (no overflow), lo_q = min + (range>>2), hi_q = max - (range>>2), each in IO_width+1 bits.
- CLASSIFY (WIN_LEN valid samples):
  - Mid-band count: increments when lo_q < sample < hi_q. Saturates at all-ones.
  - Hysteresis level: set to 1 when sample >= hi_q, cleared when sample <= lo_q, otherwise holds. Its initial value is taken from the first sample (1 if sample >= midpoint min+(range>>1)).
  - Each level change is a transition.
  - Interval counter: counts valid samples since the last transition and saturates at MAXI.
  - At the second and every later transition, min_interv = min(min_interv, interval). The counter then restarts at 1 on the next valid sample. min_interv initialises to MAXI.
- DONE: lasts exactly one cycle.
  - meas_done=1; busy drops in the same cycle.
  - Register A_const = (range < CONST_TH).
  - Register A_square = (!A_const) && (midcount <= MID_TH).
  - Register A_edge_interv = min_interv; if fewer than 2 transitions, it stays MAXI.
  - Then return to IDLE.
- Latency: meas_done is asserted 2 cycles after the clock edge that accepts the final CLASSIFY sample (one cycle to register the final transition/interval update, one to register the features and pulse meas_done).
- Outputs hold their previous values throughout a measurement. They change only in the meas_done cycle, so the downstream stage may sample them any time after meas_done.
- env_valid low stalls both passes with no state change.
- meas_start coincident with env_valid: that sample is ignored (it belongs to no window).
- A range of 0 gives lo_q = hi_q = min. No sample is mid-band and no transitions occur.

Test Plan:
- Constant envelope 1000 for 2*WIN_LEN samples (bench WIN_LEN=16) -> meas_done once; A_const=1, A_square=0, A_edge_interv=8191.
- Square envelope alternating 200/3000 every 4 samples -> A_const=0, A_square=1, A_edge_interv=4.
- Sine-like envelope with period 16 samples, range 2000 -> A_const=0, A_square=0 (midcount > MID_TH=2 in bench), A_edge_interv=8.
- Square envelope with one 2-sample dip to 200 within a 3000 plateau -> A_edge_interv=2; downstream would classify it as PSK.
- meas_start re-pulsed mid-CLASSIFY, then a constant input -> no meas_done from the first run; the second run completes with A_const=1; outputs are unchanged until then.
- rst asserted in MINMAX -> next cycle busy=0, meas_done=0, A_edge_interv=8191; with env_valid held low the FSM stays in IDLE.
